line_clear_engine: RTL

- Downstream of the game FSM. After a landed piece has been written into the ten column RAMs, the FSM pulses `start`.
- The engine scans the board bottom-up, finds full rows, and compacts the surviving rows downward. It blanks the vacated top rows and reports the number of cleared lines.
- It implements the DISTROY_LINE state: the FSM hands RAM ownership to the engine while `busy` is high.

---
 rtl/tetris_pkg.sv | 36 +++
 rtl/row_full_detect.sv | 19 +
 rtl/line_clear_engine.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board geometry, colours, engine states and score table
package tetris_pkg;

  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 10;
  localparam int COLOR_W    = 24;

  localparam logic [COLOR_W-1:0] EMPTY_CELL = 24'd0;

  localparam logic [COLOR_W-1:0] COLOR_I = 24'h00FFFF;
  localparam logic [COLOR_W-1:0] COLOR_O = 24'hFFFF00;
  localparam logic [COLOR_W-1:0] COLOR_T = 24'hA000F0;
  localparam logic [COLOR_W-1:0] COLOR_S = 24'h00F000;
  localparam logic [COLOR_W-1:0] COLOR_Z = 24'hF00000;
  localparam logic [COLOR_W-1:0] COLOR_J = 24'h0000F0;
  localparam logic [COLOR_W-1:0] COLOR_L = 24'hF0A000;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FILL, DONE} lce_state_e;

  localparam logic [10:0] SCORE_0 = 11'd0;
  localparam logic [10:0] SCORE_1 = 11'd40;
  localparam logic [10:0] SCORE_2 = 11'd100;
  localparam logic [10:0] SCORE_3 = 11'd300;
  localparam logic [10:0] SCORE_4 = 11'd1200;

  function automatic logic [10:0] score_for(input logic [4:0] n);
    case (n)
      5'd0:    return SCORE_0;
      5'd1:    return SCORE_1;
      5'd2:    return SCORE_2;
      5'd3:    return SCORE_3;
      default: return SCORE_4;
    endcase
  endfunction

endpackage

// File: rtl/row_full_detect.sv
// rtl/row_full_detect.sv - combinational check that every cell of a packed row is occupied
module row_full_detect
  import tetris_pkg::*;
#(
  parameter int NCOLS  = BOARD_COLS,
  parameter int CELL_W = COLOR_W
) (
  input  logic [NCOLS*CELL_W-1:0] row,
  output logic                    full
);

  always_comb begin
    full = 1'b1;
    for (int i = 0; i < NCOLS; i++) begin
      if (row[i*CELL_W +: CELL_W] == CELL_W'(EMPTY_CELL)) full = 1'b0;
    end
  end

endmodule

// File: rtl/line_clear_engine.sv
// rtl/line_clear_engine.sv - bottom-up full-row removal and board compaction over the column RAMs
// Optional score_delta output enabled by LINE_CLEAR_SCORE_EN.
module line_clear_engine #(
  parameter int ROWS    = tetris_pkg::BOARD_ROWS,
  parameter int COLS    = tetris_pkg::BOARD_COLS,
  parameter int COLOR_W = tetris_pkg::COLOR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [4:0]              lines_cleared,
  output logic [4:0]              ram_row,
  input  logic [COLS*COLOR_W-1:0] ram_rdata,
  output logic [COLS*COLOR_W-1:0] ram_wdata,
  output logic [COLS-1:0]         ram_we
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [10:0]             score_delta
`endif
);

  import tetris_pkg::*;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0] MAX_CNT  = 5'(ROWS);

  lce_state_e state_q, state_d;

  logic [4:0]              rd_q, wr_q, cnt_q, cnt_d, row_q;
  logic [COLS*COLOR_W-1:0] buf_q;
  logic                    full_q, row_full;

  row_full_detect #(
    .NCOLS  (COLS),
    .CELL_W (COLOR_W)
  ) u_full (
    .row  (ram_rdata),
    .full (row_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == WR && full_q && cnt_q != MAX_CNT) cnt_d = cnt_q + 5'd1;
  end

  always_comb begin
    state_d   = state_q;
    ram_row   = row_q;
    ram_wdata = '0;
    ram_we    = '0;
    case (state_q)
      IDLE: if (start) state_d = RD;
      RD: begin
        ram_row = rd_q;
        state_d = CAP;
      end
      CAP: state_d = WR;
      WR: begin
        // A surviving row already sitting at its destination needs no rewrite.
        if (!full_q && wr_q != rd_q) begin
          ram_row   = wr_q;
          ram_wdata = buf_q;
          ram_we    = '1;
        end
        if (rd_q == 5'd0) state_d = (cnt_d != 5'd0) ? FILL : DONE;
        else              state_d = RD;
      end
      FILL: begin
        ram_row = wr_q;
        ram_we  = '1;
        if (wr_q == 5'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q          <= LAST_ROW;
      wr_q          <= LAST_ROW;
      cnt_q         <= 5'd0;
      row_q         <= 5'd0;
      buf_q         <= '0;
      full_q        <= 1'b0;
      lines_cleared <= 5'd0;
    end else begin
      row_q <= ram_row;
      case (state_q)
        IDLE: if (start) begin
          rd_q  <= LAST_ROW;
          wr_q  <= LAST_ROW;
          cnt_q <= 5'd0;
        end
        CAP: begin
          buf_q  <= ram_rdata;
          full_q <= row_full;
        end
        WR: begin
          cnt_q <= cnt_d;
          if (!full_q && wr_q != 5'd0) wr_q <= wr_q - 5'd1;
          if (rd_q != 5'd0)            rd_q <= rd_q - 5'd1;
        end
        FILL: if (wr_q != 5'd0) wr_q <= wr_q - 5'd1;
        default: ;
      endcase
      if (state_d == DONE) lines_cleared <= cnt_d;
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                score_delta <= 11'd0;
    else if (state_d == DONE)  score_delta <= score_for(cnt_d);
  end
`endif

endmodule
